ddr_wr_buf: RTL
===============

Name: ddr_wr_buf

Overview:
- Camera-side write buffer, the write-direction counterpart of the DDR read line buffer.
- Packs an RGB565 pixel stream (href/vsync framing) into 256-bit DDR words and stores them in a two-bank ping-pong line RAM.
- Presents each complete line, tagged with its row number, to the AXI write master, which pulls the words out and releases the bank.
- Single clock; pixel inputs are already synchronous to clk.

Parameters:
- DQ_WIDTH, 32, DDR DQ width; word width is DQ_WIDTH*8 = 256 bits.
- H_WIDTH, 1280, pixels per line.
- H_HEIGHT, 720, lines per frame.

Ports:
- clk  input  1  clock for all logic.
- rst  input  1  asynchronous, active-high reset.
- vsync_i  input  1  frame sync; its rising edge starts a frame.
- href_i  input  1  line valid; high for the whole line.
- pix_en  input  1  pix_data is valid this cycle (honoured only while href_i is high).
- pix_data  input  16  RGB565 pixel.
- line_rdy  output  1  a complete line is available for reading.
- line_row  output  10  row number (0-based) of the line being offered.
- buf_rd_en  input  1  read the next word of the offered line.
- buf_rd_data  output  DQ_WIDTH*8  word data, valid 1 cycle after buf_rd_en.
- line_done  input  1  pulse: offered line fully written to DDR; release its bank.
- overflow  output  1  1-cycle pulse: a line was dropped because its target bank was still full.
- short_line  output  1  1-cycle pulse: a line ended with fewer than H_WIDTH pixels and was discarded.

Behaviour:
- Derived constants:
  - PIX_PER_WORD = DQ_WIDTH*8/16 = 16.
  - WORDS_PER_LINE = H_WIDTH/PIX_PER_WORD = 80.
  - Word address is 7 bits; RAM address is {bank, addr}, 8 bits.
- Reset: all counters are 0, wr_bank = rd_bank = 0, both full flags are 0, and every output is 0 (line_rdy, line_row, buf_rd_data, overflow, short_line).
- Edge detection: vsync_i and href_i are registered once; rising and falling edges are taken against those registered copies.
- Packing:
  - Pixel k of a word occupies bits [16k+15:16k]; the first pixel goes to [15:0].
  - On the 16th pixel, the assembled word is written to RAM at {wr_bank, wr_addr} on the same cycle the last pixel is captured, and wr_addr increments.
  - Pixels arriving after word 79 of a line are ignored.
- Line start (href_i rising edge):
  - Pack count and wr_addr are cleared.
  - If full[wr_bank] = 1, the line is marked dropped: no RAM writes are made, overflow pulses, and the row counter still advances at the line end.
- Line end (href_i falling edge):
  - If the line is not dropped and wr_addr = 80: set full[wr_bank], store the row number in row_tag[wr_bank], toggle wr_bank.
  - If the line is not dropped and wr_addr < 80: discard the line, pulse short_line, leave the bank unchanged.
  - In every case the row counter increments, saturating at H_HEIGHT-1.
- Frame start (vsync_i rising edge):
  - Row counter is cleared and any in-progress pack or line is abandoned without error pulses.
  - Committed full banks are kept and still drained.
- Read side:
  - line_rdy = full[rd_bank]; line_row = row_tag[rd_bank].
  - buf_rd_en while line_rdy = 1 and rd_addr < 80: RAM read at {rd_bank, rd_addr}; buf_rd_data updates on the next cycle; rd_addr increments.
  - buf_rd_en at any other time is ignored, and buf_rd_data holds its value.
- Release:
  - line_done while line_rdy = 1 clears full[rd_bank], toggles rd_bank and clears rd_addr.
  - line_done while line_rdy = 0 is ignored.
  - line_done is legal before all 80 words are read; the remaining words are abandoned.
- Simultaneous events:
  - A line commit and a line_done on different banks in the same cycle both take effect.
  - If a commit fills the bank being released in that same cycle (impossible in ping-pong order), it is treated as a commit after the release.
  - A vsync edge and an href edge in the same cycle: the vsync edge is processed first, then the href edge.
- Reset mid-operation returns everything to reset values immediately; RAM contents are don't-care.

Decomposition:
- Shared package constants: PIX_PER_WORD, WORDS_PER_LINE, WORD_AW (7) and ROW_W (10). The read buffer uses the same constants.
- Sub-module ddr_wr_line_ram:
  - Simple dual-port RAM, 256 x 256 bits.
  - One write port and one read port.
  - Registered read with 1-cycle latency.
  - Single clock.

Test Plan:
- Reset, then one 1280-pixel line with pix_data = pixel index -> line_rdy = 1, line_row = 0. Issue 80 consecutive buf_rd_en -> word 0 has [15:0] = 0x0000 and [255:240] = 0x000F, word 79 has [255:240] = 0x04FF, each word 1 cycle after its buf_rd_en. Then line_done -> line_rdy = 0.
- Three lines with no line_done -> lines 0 and 1 are committed; line 2 gives overflow = 1 for 1 cycle at its href rise. Drain both lines -> line_row is 0, then 1. The next line commits with line_row = 3.
- Line with only 1000 pixels -> short_line pulses at the href fall; line_rdy stays 0; the next full line is tagged row 1.
- pix_en toggled every other cycle across a full line -> the output words are identical to the back-to-back case.
- vsync rising edge mid-line after 500 pixels -> no commit and no pulses; the following line is tagged row 0. A bank committed before the vsync edge is still offered.
- Assert rst while line_rdy = 1 and a pack is in progress -> all outputs are 0 on the next edge. A new frame after reset behaves as in scenario 1.

Source files
------------

// File: rtl/ddr_wr_buf_pkg.sv
// Shared constants and types for the camera-side DDR write line buffer.
// The read-side line buffer uses the same constants.
package ddr_wr_buf_pkg;
  localparam int PIX_W          = 16;
  localparam int PIX_PER_WORD   = 16;
  localparam int WORDS_PER_LINE = 80;
  localparam int WORD_AW        = 7;
  localparam int ROW_W          = 10;

  typedef enum logic [1:0] {
    L_IDLE,
    L_PACK,
    L_DROP
  } line_state_t;
endpackage

// File: rtl/ddr_wr_buf_if.sv
// Pixel-stream and line-read bus of the write buffer.
// The slave modport is the buffer side; the master modport is the camera/AXI side.
interface ddr_wr_buf_if
  import ddr_wr_buf_pkg::*;
#(
  parameter int DQ_WIDTH = 32
);
  logic                  vsync_i;
  logic                  href_i;
  logic                  pix_en;
  logic [PIX_W-1:0]      pix_data;
  logic                  line_rdy;
  logic [ROW_W-1:0]      line_row;
  logic                  buf_rd_en;
  logic [DQ_WIDTH*8-1:0] buf_rd_data;
  logic                  line_done;
  logic                  overflow;
  logic                  short_line;

  modport slave (
    input  vsync_i, href_i, pix_en, pix_data, buf_rd_en, line_done,
    output line_rdy, line_row, buf_rd_data, overflow, short_line
  );

  modport master (
    output vsync_i, href_i, pix_en, pix_data, buf_rd_en, line_done,
    input  line_rdy, line_row, buf_rd_data, overflow, short_line
  );
endinterface

// File: rtl/ddr_wr_line_ram.sv
// Simple dual-port line RAM: one write port, one registered read port.
// The read register holds its value when no read is issued.
module ddr_wr_line_ram #(
  parameter int AW = 8,
  parameter int DW = 256
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/ddr_wr_buf.sv
// Packs RGB565 pixels into DDR words and stores complete lines in a
// two-bank ping-pong RAM, offering each committed line with its row tag.
module ddr_wr_buf
  import ddr_wr_buf_pkg::*;
#(
  parameter int DQ_WIDTH = 32,
  parameter int H_WIDTH  = 1280,
  parameter int H_HEIGHT = 720
) (
  input logic        clk,
  input logic        rst,
  ddr_wr_buf_if.slave bus
);
  localparam int WORD_W = DQ_WIDTH * 8;
  localparam int PPW    = WORD_W / PIX_W;
  localparam int WPL    = H_WIDTH / PPW;
  localparam int PCW    = $clog2(PPW);
  localparam int RAM_AW = WORD_AW + 1;

  line_state_t state, state_nxt;

  logic                    vsync_q, href_q;
  logic                    vs_rise, href_rise, href_fall;
  logic [PCW-1:0]          pack_cnt, eff_cnt;
  logic [WORD_AW-1:0]      wr_addr, eff_addr, rd_addr;
  logic [WORD_W-PIX_W-1:0] pack_reg;
  logic [PCW+$clog2(PIX_W)-1:0] pix_lsb;
  logic [ROW_W-1:0]        row_cnt;
  logic [ROW_W-1:0]        row_tag [2];
  logic [1:0]              full;
  logic                    wr_bank, rd_bank;
  logic                    line_start, line_end, commit, short_evt, ovf_evt;
  logic                    capture, word_wr, rd_fire, release_line;
  logic                    overflow_q, short_q;

  assign vs_rise   = bus.vsync_i & ~vsync_q;
  assign href_rise = bus.href_i & ~href_q;
  assign href_fall = ~bus.href_i & href_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= L_IDLE;
    else     state <= state_nxt;
  end

  // A vsync edge abandons the current line before any href edge of the same cycle is applied.
  always_comb begin
    state_nxt  = state;
    line_start = 1'b0;
    line_end   = 1'b0;
    commit     = 1'b0;
    short_evt  = 1'b0;
    ovf_evt    = 1'b0;
    if (vs_rise) state_nxt = L_IDLE;
    if (href_rise) begin
      line_start = 1'b1;
      ovf_evt    = full[wr_bank];
      state_nxt  = full[wr_bank] ? L_DROP : L_PACK;
    end else if (href_fall && state_nxt != L_IDLE) begin
      line_end = 1'b1;
      if (state_nxt == L_PACK) begin
        if (wr_addr == WORD_AW'(WPL)) commit    = 1'b1;
        else                          short_evt = 1'b1;
      end
      state_nxt = L_IDLE;
    end
  end

  assign eff_cnt      = line_start ? '0 : pack_cnt;
  assign eff_addr     = line_start ? '0 : wr_addr;
  assign pix_lsb      = {eff_cnt, {$clog2(PIX_W){1'b0}}};
  assign capture      = (state_nxt == L_PACK) && bus.href_i && bus.pix_en &&
                        (eff_addr < WORD_AW'(WPL));
  assign word_wr      = capture && (eff_cnt == PCW'(PPW - 1));
  assign release_line = bus.line_done & full[rd_bank];
  assign rd_fire      = bus.buf_rd_en & full[rd_bank] & (rd_addr < WORD_AW'(WPL));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vsync_q  <= 1'b0;
      href_q   <= 1'b0;
      pack_cnt <= '0;
      wr_addr  <= '0;
      pack_reg <= '0;
    end else begin
      vsync_q  <= bus.vsync_i;
      href_q   <= bus.href_i;
      pack_cnt <= capture ? eff_cnt + 1'b1 : eff_cnt;
      wr_addr  <= word_wr ? eff_addr + 1'b1 : eff_addr;
      if (capture && !word_wr) pack_reg[pix_lsb +: PIX_W] <= bus.pix_data;
    end
  end

  // A commit landing on the bank being released wins, as if it came after the release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_cnt    <= '0;
      row_tag[0] <= '0;
      row_tag[1] <= '0;
      full       <= '0;
      wr_bank    <= 1'b0;
      rd_bank    <= 1'b0;
      rd_addr    <= '0;
      overflow_q <= 1'b0;
      short_q    <= 1'b0;
    end else begin
      overflow_q <= ovf_evt;
      short_q    <= short_evt;
      if (vs_rise) row_cnt <= '0;
      else if (line_end && row_cnt != ROW_W'(H_HEIGHT - 1)) row_cnt <= row_cnt + 1'b1;
      if (release_line) begin
        full[rd_bank] <= 1'b0;
        rd_bank       <= ~rd_bank;
        rd_addr       <= '0;
      end else if (rd_fire) begin
        rd_addr <= rd_addr + 1'b1;
      end
      if (commit) begin
        full[wr_bank]    <= 1'b1;
        row_tag[wr_bank] <= row_cnt;
        wr_bank          <= ~wr_bank;
      end
    end
  end

  ddr_wr_line_ram #(
    .AW(RAM_AW),
    .DW(WORD_W)
  ) u_ram (
    .clk  (clk),
    .rst  (rst),
    .we   (word_wr),
    .waddr({wr_bank, eff_addr}),
    .wdata({bus.pix_data, pack_reg}),
    .re   (rd_fire),
    .raddr({rd_bank, rd_addr}),
    .rdata(bus.buf_rd_data)
  );

  assign bus.line_rdy   = full[rd_bank];
  assign bus.line_row   = row_tag[rd_bank];
  assign bus.overflow   = overflow_q;
  assign bus.short_line = short_q;
endmodule
